mdu_iter: RTL and testbench

- Parametrised iterative multiply/divide unit implementing the full RV32M op set (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU).
- Successor to the single-cycle MUL-only path. Generalised in operand width and in bits retired per cycle, and adds division, a valid/ready handshake and flush.
- Sits beside the ALU in the execute stage; its result feeds the WB_MUL writeback leg.

---
 rtl/mdu_iter.sv | 227 ++++++++++++++++++++++
 tb/tb_mdu_iter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_iter.sv
// mdu_iter: iterative RV32M multiply/divide unit.
//   Shift-add multiply and restoring divide, BITS_PER_CYCLE bits per
//   iteration, with sign fix-up in a single FIX cycle.
// Ports:
//   clk, reset_n      clock (rising edge), synchronous active-low reset
//   flush             abort any operation in flight
//   in_valid/in_ready request handshake (op, rs1, rs2 latched on accept)
//   op                funct3: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
//   out_valid/out_ready result handshake; result held until accepted
//   result            result word, holds last value between operations
//   busy              operation in flight or result pending
module mdu_iter #(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned BITS_PER_CYCLE = 1,
  parameter int unsigned FAST_SPECIAL   = 1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam int unsigned NITER = XLEN / BITS_PER_CYCLE;
  localparam int unsigned CW    = $clog2(NITER + 1);
  localparam int unsigned AW    = 2 * XLEN + 1;
  localparam int unsigned SW    = XLEN + BITS_PER_CYCLE + 1;
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_FIX,
    S_DONE
  } state_e;

  state_e state_q, state_d;

  logic [2:0]      op_q, op_d;
  logic            sign_a_q, sign_a_d;
  logic            sign_b_q, sign_b_d;
  logic            special_q, special_d;
  logic            bzero_q, bzero_d;
  logic [XLEN-1:0] b_q, b_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [AW-1:0]   acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  // ---------------- request decode ----------------
  logic            accept;
  logic            in_sa, in_sb;
  logic            in_div_zero, in_ovf, in_special;
  logic [XLEN-1:0] a_abs, b_abs, special_res;

  assign accept = (state_q == S_IDLE) && in_valid && !flush;

  always_comb begin
    in_sa = 1'b0;
    in_sb = 1'b0;
    case (op)
      3'b001:         begin in_sa = rs1[XLEN-1]; in_sb = rs2[XLEN-1]; end
      3'b010:         in_sa = rs1[XLEN-1];
      3'b100, 3'b110: begin in_sa = rs1[XLEN-1]; in_sb = rs2[XLEN-1]; end
      default:        ;
    endcase
    a_abs = in_sa ? -rs1 : rs1;
    b_abs = in_sb ? -rs2 : rs2;

    in_div_zero = (rs2 == '0);
    in_ovf      = !op[0] && (rs1 == MOST_NEG) && (rs2 == '1);
    in_special  = (FAST_SPECIAL != 0) && op[2] && (in_div_zero || in_ovf);

    if (in_div_zero) special_res = op[1] ? rs1 : '1;
    else             special_res = op[1] ? '0 : MOST_NEG;
  end

  // ---------------- iteration steps ----------------
  // acc layout: {hi (XLEN+1), lo (XLEN)}. Multiply consumes lo from the
  // bottom while the product shifts in from the top; divide keeps the
  // partial remainder in hi and shifts quotient bits into lo.
  logic [SW-1:0]   mul_sum;
  logic [AW-1:0]   mul_step;
  logic [AW-1:0]   div_step;
  logic [XLEN:0]   div_trial;

  always_comb begin
    mul_sum = {{BITS_PER_CYCLE{1'b0}}, acc_q[AW-1:XLEN]};
    for (int unsigned j = 0; j < BITS_PER_CYCLE; j++) begin
      if (acc_q[j]) mul_sum = mul_sum + (SW'(b_q) << j);
    end
    mul_step = {mul_sum, acc_q[XLEN-1:BITS_PER_CYCLE]};
  end

  always_comb begin
    div_step  = acc_q;
    div_trial = '0;
    for (int unsigned j = 0; j < BITS_PER_CYCLE; j++) begin
      div_step  = div_step << 1;
      div_trial = div_step[AW-1:XLEN] - {1'b0, b_q};
      if (!div_trial[XLEN]) begin
        div_step[AW-1:XLEN] = div_trial;
        div_step[0]         = 1'b1;
      end
    end
  end

  // ---------------- sign fix-up / output select ----------------
  logic [2*XLEN-1:0] fix_prod;
  logic [XLEN-1:0]   fix_quo, fix_rem, fix_res;

  always_comb begin
    fix_prod = acc_q[2*XLEN-1:0];
    if (sign_a_q ^ sign_b_q) fix_prod = -fix_prod;
    // Divide-by-zero must yield all-ones regardless of dividend sign.
    fix_quo = acc_q[XLEN-1:0];
    if ((sign_a_q ^ sign_b_q) && !bzero_q) fix_quo = -fix_quo;
    fix_rem = acc_q[2*XLEN-1:XLEN];
    if (sign_a_q) fix_rem = -fix_rem;

    case (op_q)
      3'b000:                 fix_res = fix_prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fix_res = fix_prod[2*XLEN-1:XLEN];
      3'b100, 3'b101:         fix_res = fix_quo;
      default:                fix_res = fix_rem;
    endcase
    if (special_q) fix_res = acc_q[XLEN-1:0];
  end

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  // Fast special cases skip BUSY but still pass through FIX, which
  // registers the pre-computed special result one cycle after accept.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = in_special ? S_FIX : S_BUSY;
      S_BUSY: begin
        if (flush)                  state_d = S_IDLE;
        else if (cnt_q == CW'(1))   state_d = S_FIX;
      end
      S_FIX:  state_d = flush ? S_IDLE : S_DONE;
      S_DONE: if (flush || out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_DONE);
    busy      = (state_q != S_IDLE);
  end

  assign result = result_q;

  // ---------------- datapath ----------------
  always_comb begin
    op_d      = op_q;
    sign_a_d  = sign_a_q;
    sign_b_d  = sign_b_q;
    special_d = special_q;
    bzero_d   = bzero_q;
    b_d       = b_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d      = op;
          sign_a_d  = in_sa;
          sign_b_d  = in_sb;
          special_d = in_special;
          bzero_d   = in_div_zero;
          b_d       = b_abs;
          cnt_d     = CW'(NITER);
          acc_d     = in_special ? AW'(special_res) : AW'(a_abs);
        end
      end
      S_BUSY: begin
        acc_d = op_q[2] ? div_step : mul_step;
        cnt_d = cnt_q - CW'(1);
      end
      S_FIX: begin
        if (!flush) result_d = fix_res;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      op_q      <= '0;
      sign_a_q  <= 1'b0;
      sign_b_q  <= 1'b0;
      special_q <= 1'b0;
      bzero_q   <= 1'b0;
      b_q       <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
    end else begin
      op_q      <= op_d;
      sign_a_q  <= sign_a_d;
      sign_b_q  <= sign_b_d;
      special_q <= special_d;
      bzero_q   <= bzero_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
    end
  end

endmodule

// File: tb/tb_mdu_iter.sv
// tb_mdu_iter: directed-vector bench for mdu_iter. Four instances share
// the inputs: (BPC=1,FAST=1), (BPC=1,FAST=0), (BPC=4,FAST=1), (BPC=2,FAST=0).
module tb_mdu_iter;

  localparam int NDUT = 4;

  logic        clk;
  logic        reset_n;
  logic        flush;
  logic        in_valid;
  logic        out_ready;
  logic [2:0]  op;
  logic [31:0] rs1;
  logic [31:0] rs2;

  logic        ir  [NDUT];
  logic        ov  [NDUT];
  logic        bsy [NDUT];
  logic [31:0] res [NDUT];

  int n_checks = 0;
  int n_pass   = 0;

  mdu_iter #(.XLEN(32), .BITS_PER_CYCLE(1), .FAST_SPECIAL(1)) dut0 (
    .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(in_valid),
    .in_ready(ir[0]), .op(op), .rs1(rs1), .rs2(rs2), .out_valid(ov[0]),
    .out_ready(out_ready), .result(res[0]), .busy(bsy[0]));

  mdu_iter #(.XLEN(32), .BITS_PER_CYCLE(1), .FAST_SPECIAL(0)) dut1 (
    .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(in_valid),
    .in_ready(ir[1]), .op(op), .rs1(rs1), .rs2(rs2), .out_valid(ov[1]),
    .out_ready(out_ready), .result(res[1]), .busy(bsy[1]));

  mdu_iter #(.XLEN(32), .BITS_PER_CYCLE(4), .FAST_SPECIAL(1)) dut2 (
    .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(in_valid),
    .in_ready(ir[2]), .op(op), .rs1(rs1), .rs2(rs2), .out_valid(ov[2]),
    .out_ready(out_ready), .result(res[2]), .busy(bsy[2]));

  mdu_iter #(.XLEN(32), .BITS_PER_CYCLE(2), .FAST_SPECIAL(0)) dut3 (
    .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(in_valid),
    .in_ready(ir[3]), .op(op), .rs1(rs1), .rs2(rs2), .out_valid(ov[3]),
    .out_ready(out_ready), .result(res[3]), .busy(bsy[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  function automatic bit is_special(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    return o[2] && ((b == 32'h0) || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  function automatic int exp_lat(input int i, input bit sp);
    if (sp && (i == 0 || i == 2)) return 1;
    case (i)
      0, 1:    return 33;
      2:       return 9;
      default: return 17;
    endcase
  endfunction

  function automatic logic [31:0] ref_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb;
    longint unsigned ua, ub;
    logic [63:0]     p;
    logic [31:0]     r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'h0, a};
    ub = {32'h0, b};
    r  = '0;
    case (o)
      3'd0: begin p = ua * ub;           r = p[31:0];  end
      3'd1: begin p = sa * sb;           r = p[63:32]; end
      3'd2: begin p = sa * longint'(ub); r = p[63:32]; end
      3'd3: begin p = ua * ub;           r = p[63:32]; end
      3'd4: begin
        if (b == 0) r = 32'hFFFF_FFFF;
        else begin p = sa / sb; r = p[31:0]; end
      end
      3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) r = a;
        else begin p = sa % sb; r = p[31:0]; end
      end
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  // Issue one request, check each instance's result and latency, optionally
  // hold out_ready low for `hold` extra cycles, then accept the results.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int hold);
    int lat [NDUT];
    bit sp;
    bit all_seen;
    sp = is_special(o, a, b);
    for (int i = 0; i < NDUT; i++) lat[i] = -1;
    op = o; rs1 = a; rs2 = b; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int c = 0; c <= 60; c++) begin
      all_seen = 1'b1;
      for (int i = 0; i < NDUT; i++) begin
        if (lat[i] < 0 && ov[i]) begin
          lat[i] = c;
          check_eq($sformatf("%s dut%0d result", tag, i), res[i], exp);
        end
        if (lat[i] < 0) all_seen = 1'b0;
      end
      if (all_seen) break;
      @(negedge clk);
    end
    for (int i = 0; i < NDUT; i++)
      check_eq($sformatf("%s dut%0d latency", tag, i), 32'(lat[i]), 32'(exp_lat(i, sp)));
    repeat (hold) begin
      @(negedge clk);
      for (int i = 0; i < NDUT; i++) begin
        check_eq($sformatf("%s dut%0d held result", tag, i), res[i], exp);
        check_eq($sformatf("%s dut%0d held in_ready", tag, i), 32'(ir[i]), 32'd0);
        check_eq($sformatf("%s dut%0d held out_valid", tag, i), 32'(ov[i]), 32'd1);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    logic [2:0]  o;
    logic [31:0] a, b;
    int          seen;

    reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op = '0; rs1 = '0; rs2 = '0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < NDUT; i++) begin
      check_eq($sformatf("reset dut%0d in_ready", i), 32'(ir[i]), 32'd1);
      check_eq($sformatf("reset dut%0d out_valid", i), 32'(ov[i]), 32'd0);
      check_eq($sformatf("reset dut%0d busy", i), 32'(bsy[i]), 32'd0);
      check_eq($sformatf("reset dut%0d result", i), res[i], 32'd0);
    end
    reset_n = 1'b1;
    @(negedge clk);

    // Multiply set
    run_op("MUL",    3'd0, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFE, 0);
    run_op("MULH",   3'd1, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 0);
    run_op("MULHSU", 3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 0);
    run_op("MULHU",  3'd3, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 0);
    run_op("MULHU_max", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0);
    run_op("MULH_neg", 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 0);

    // Divide set
    run_op("DIV",  3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 0);
    run_op("REM",  3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 0);
    run_op("DIVU", 3'd5, 32'hFFFF_FFF9, 32'h0000_0002, 32'h7FFF_FFFC, 0);
    run_op("REMU", 3'd7, 32'hFFFF_FFF9, 32'h0000_0002, 32'h0000_0001, 0);

    // Special divide cases
    run_op("DIV_by0",  3'd4, 32'h0000_0005, 32'h0, 32'hFFFF_FFFF, 0);
    run_op("REM_by0",  3'd6, 32'h0000_0005, 32'h0, 32'h0000_0005, 0);
    run_op("DIVn_by0", 3'd4, 32'hFFFF_FFF9, 32'h0, 32'hFFFF_FFFF, 0);
    run_op("REMn_by0", 3'd6, 32'hFFFF_FFF9, 32'h0, 32'hFFFF_FFF9, 0);
    run_op("DIVU_by0", 3'd5, 32'h0000_0005, 32'h0, 32'hFFFF_FFFF, 0);
    run_op("REMU_by0", 3'd7, 32'h1234_5678, 32'h0, 32'h1234_5678, 0);
    run_op("DIV_ovf",  3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
    run_op("REM_ovf",  3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 0);

    // Backpressure: result held with out_ready low for 10 cycles
    run_op("MUL_bp", 3'd0, 32'd7, 32'd6, 32'd42, 10);

    // Reset while busy
    op = 3'd4; rs1 = 32'd100; rs2 = 32'd7; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    for (int i = 0; i < NDUT; i++) begin
      check_eq($sformatf("rst_busy dut%0d in_ready", i), 32'(ir[i]), 32'd1);
      check_eq($sformatf("rst_busy dut%0d out_valid", i), 32'(ov[i]), 32'd0);
      check_eq($sformatf("rst_busy dut%0d result", i), res[i], 32'd0);
    end
    reset_n = 1'b1;
    @(negedge clk);
    run_op("MUL_after_rst", 3'd0, 32'd3, 32'd4, 32'd12, 0);

    // Flush mid-BUSY
    op = 3'd4; rs1 = 32'd100; rs2 = 32'd7; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    for (int i = 0; i < NDUT; i++) begin
      check_eq($sformatf("flush dut%0d in_ready", i), 32'(ir[i]), 32'd1);
      check_eq($sformatf("flush dut%0d out_valid", i), 32'(ov[i]), 32'd0);
    end
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      for (int i = 0; i < NDUT; i++) if (ov[i]) seen++;
    end
    check_eq("flush out_valid count", 32'(seen), 32'd0);
    for (int i = 0; i < NDUT; i++)
      check_eq($sformatf("flush dut%0d result kept", i), res[i], 32'd12);

    // Flush together with in_valid in IDLE: request must be ignored
    op = 3'd4; rs1 = 32'd5; rs2 = 32'd0; in_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    for (int i = 0; i < NDUT; i++)
      check_eq($sformatf("idle_flush dut%0d in_ready", i), 32'(ir[i]), 32'd1);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      for (int i = 0; i < NDUT; i++) if (ov[i]) seen++;
    end
    check_eq("idle_flush out_valid count", 32'(seen), 32'd0);

    // Random operations against the reference model
    for (int k = 0; k < 150; k++) begin
      o = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 9))
        0: b = 32'h0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 15));
        3: a = 32'h8000_0000;
        4: b = 32'hFFFF_FFFF;
        default: ;
      endcase
      run_op($sformatf("rnd%0d op%0d", k, o), o, a, b, ref_op(o, a, b), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
